// File: rtl/scr1_axi_bridge_pkg.sv
// Shared types and helpers for the SCR1 AXI4 to AXI-lite burst bridge.
package scr1_axi_bridge_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP, W_BOUT} wr_state_e;

  // The more severe response (numerically larger) dominates a merged burst.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axil_if.sv
// AXI-lite bus bundle between the bridge and the fabric.
interface axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic              b_valid;
  logic              b_ready;
  logic [1:0]        b_resp;
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;

  modport Master (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport Slave (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/scr1_axi_burst_addr.sv
// Combinational AXI4 next-beat address calculator (FIXED/INCR/WRAP; reserved acts as INCR).
module scr1_axi_burst_addr
  import scr1_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  input  logic [7:0]        i_len,
  input  burst_e            i_burst,
  output logic [ADDR_W-1:0] o_next_addr
);

  logic [ADDR_W-1:0] w_bytes;
  logic [ADDR_W-1:0] w_incr;
  logic [ADDR_W-1:0] w_mask;

  assign w_bytes = ADDR_W'(1) << i_size;
  assign w_incr  = i_addr + w_bytes;
  // Legal wrap lengths make the span a power of two, so span-1 is the offset mask.
  assign w_mask  = (w_bytes * (ADDR_W'(i_len) + ADDR_W'(1))) - ADDR_W'(1);

  always_comb begin
    o_next_addr = w_incr;
    case (i_burst)
      BURST_FIXED: o_next_addr = i_addr;
      BURST_WRAP:  o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
      default:     o_next_addr = w_incr;
    endcase
  end

endmodule

// File: rtl/scr1_axi4_to_axil_bridge.sv
// AXI4 slave to AXI-lite master bridge: splits bursts into single lite beats,
// returns IDs, generates rlast and merges per-beat write responses.
module scr1_axi4_to_axil_bridge
  import scr1_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready,
  axil_if.Master              m_axil,
  output logic                wlast_err
);

  logic r_live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // ---------------- read path ----------------
  rd_state_e         r_rstate, w_rnext;
  logic [ID_W-1:0]   r_rid;
  logic [ADDR_W-1:0] r_raddr, w_raddr_nxt;
  logic [7:0]        r_rlen, r_rcnt;
  logic [2:0]        r_rsize;
  burst_e            r_rburst;
  logic              w_rfinal, w_r_hs;

  assign w_rfinal = (r_rcnt == r_rlen);
  assign w_r_hs   = (r_rstate == R_DATA) && m_axil.r_valid && s_rready;

  scr1_axi_burst_addr #(.ADDR_W(ADDR_W)) u_rd_addr (
    .i_addr(r_raddr), .i_size(r_rsize), .i_len(r_rlen), .i_burst(r_rburst), .o_next_addr(w_raddr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rstate <= R_IDLE;
    else        r_rstate <= w_rnext;
  end

  always_comb begin
    w_rnext         = r_rstate;
    s_arready       = 1'b0;
    m_axil.ar_valid = 1'b0;
    m_axil.r_ready  = 1'b0;
    s_rvalid        = 1'b0;
    s_rdata         = '0;
    s_rresp         = RESP_OKAY;
    s_rlast         = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        s_arready = r_live;
        if (r_live && s_arvalid) w_rnext = R_ADDR;
      end
      R_ADDR: begin
        m_axil.ar_valid = 1'b1;
        if (m_axil.ar_ready) w_rnext = R_DATA;
      end
      R_DATA: begin
        s_rvalid       = m_axil.r_valid;
        m_axil.r_ready = s_rready;
        s_rdata        = m_axil.r_data;
        s_rresp        = (r_rburst == BURST_RSVD) ? resp_merge(m_axil.r_resp, RESP_SLVERR) : m_axil.r_resp;
        s_rlast        = w_rfinal;
        if (w_r_hs) w_rnext = w_rfinal ? R_IDLE : R_ADDR;
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rsize  <= '0;
      r_rburst <= BURST_FIXED;
    end else if (r_rstate == R_IDLE && r_live && s_arvalid) begin
      r_rid    <= s_arid;
      r_raddr  <= s_araddr;
      r_rlen   <= s_arlen;
      r_rcnt   <= '0;
      r_rsize  <= s_arsize;
      r_rburst <= burst_e'(s_arburst);
    end else if (w_r_hs && !w_rfinal) begin
      r_raddr <= w_raddr_nxt;
      r_rcnt  <= r_rcnt + 8'd1;
    end
  end

  assign m_axil.ar_addr = r_raddr;
  assign s_rid          = r_rid;

  // ---------------- write path ----------------
  wr_state_e         r_wstate, w_wnext;
  logic [ID_W-1:0]   r_wid;
  logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
  logic [7:0]        r_wlen, r_wcnt;
  logic [2:0]        r_wsize;
  burst_e            r_wburst;
  logic [1:0]        r_wresp;
  logic              r_aw_done, r_w_done, r_wlast_err;
  logic              w_wfinal, w_aw_vld, w_w_vld, w_aw_hs, w_w_hs, w_beat_done;

  assign w_wfinal = (r_wcnt == r_wlen);
  // Lite AW and W are only offered once the AXI4 beat is present, and each drops after its own handshake.
  assign w_aw_vld    = (r_wstate == W_XFER) && s_wvalid && !r_aw_done;
  assign w_w_vld     = (r_wstate == W_XFER) && s_wvalid && !r_w_done;
  assign w_aw_hs     = w_aw_vld && m_axil.aw_ready;
  assign w_w_hs      = w_w_vld && m_axil.w_ready;
  assign w_beat_done = (r_wstate == W_XFER) && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  scr1_axi_burst_addr #(.ADDR_W(ADDR_W)) u_wr_addr (
    .i_addr(r_waddr), .i_size(r_wsize), .i_len(r_wlen), .i_burst(r_wburst), .o_next_addr(w_waddr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wstate <= W_IDLE;
    else        r_wstate <= w_wnext;
  end

  always_comb begin
    w_wnext         = r_wstate;
    s_awready       = 1'b0;
    s_wready        = 1'b0;
    s_bvalid        = 1'b0;
    s_bresp         = RESP_OKAY;
    m_axil.aw_valid = 1'b0;
    m_axil.w_valid  = 1'b0;
    m_axil.w_data   = '0;
    m_axil.w_strb   = '0;
    m_axil.b_ready  = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        s_awready = r_live;
        if (r_live && s_awvalid) w_wnext = W_XFER;
      end
      W_XFER: begin
        m_axil.aw_valid = w_aw_vld;
        m_axil.w_valid  = w_w_vld;
        m_axil.w_data   = s_wdata;
        m_axil.w_strb   = s_wstrb;
        s_wready        = w_beat_done;
        if (w_beat_done) w_wnext = W_RESP;
      end
      W_RESP: begin
        m_axil.b_ready = 1'b1;
        if (m_axil.b_valid) w_wnext = w_wfinal ? W_BOUT : W_XFER;
      end
      W_BOUT: begin
        s_bvalid = 1'b1;
        s_bresp  = r_wresp;
        if (s_bready) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wid       <= '0;
      r_waddr     <= '0;
      r_wlen      <= '0;
      r_wcnt      <= '0;
      r_wsize     <= '0;
      r_wburst    <= BURST_FIXED;
      r_wresp     <= RESP_OKAY;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_wlast_err <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: if (r_live && s_awvalid) begin
          r_wid     <= s_awid;
          r_waddr   <= s_awaddr;
          r_wlen    <= s_awlen;
          r_wcnt    <= '0;
          r_wsize   <= s_awsize;
          r_wburst  <= burst_e'(s_awburst);
          r_wresp   <= RESP_OKAY;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
        W_XFER: if (w_beat_done) begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (s_wlast != w_wfinal) begin
            r_wlast_err <= 1'b1;
            r_wresp     <= resp_merge(r_wresp, RESP_SLVERR);
          end
        end else begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        W_RESP: if (m_axil.b_valid) begin
          r_wresp <= resp_merge(r_wresp, resp_merge(m_axil.b_resp,
                     (r_wburst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY));
          if (!w_wfinal) begin
            r_waddr <= w_waddr_nxt;
            r_wcnt  <= r_wcnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axil.aw_addr = r_waddr;
  assign s_bid          = r_wid;
  assign wlast_err      = r_wlast_err;

endmodule
